conv_window_gen: RTL and testbench

- Producer side of the conv filter's 3x3 window interface.
- Takes a raster-order pixel stream (one 32-bit float word per beat) for one feature-map plane.
- Using two line buffers and a 3x3 shift window, emits one 9-word window per valid output position (no padding, stride 1).
- Sits between the feature-map memory reader and the filter/MAC array; output words are ordered for direct connection to the filter's data inputs.

---
 rtl/cnn_pkg.sv | 24 ++
 rtl/conv_window_gen_if.sv | 40 ++++
 rtl/conv_window_gen_line_buffer.sv | 38 +++
 rtl/conv_window_gen.sv | 206 ++++++++++++++++++++
 tb/tb_conv_window_gen.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared constants and types for the conv window generator and its users.
//   DATA_W      : pixel word width (IEEE-754 single, carried as raw bits)
//   KERNEL_SIZE : window edge length (3x3 window)
//   WIN_N       : number of words in one window
//   win_t       : one window, element [0]=top-left ... [8]=bottom-right
//   state_e     : control states of the window generator
// -----------------------------------------------------------------------------
package cnn_pkg;

    localparam int DATA_W      = 32;
    localparam int KERNEL_SIZE = 3;
    localparam int WIN_N       = KERNEL_SIZE * KERNEL_SIZE;

    typedef logic [DATA_W-1:0] win_t [0:WIN_N-1];

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FLUSH  = 2'd2
    } state_e;

endpackage : cnn_pkg

// File: rtl/conv_window_gen_if.sv
// -----------------------------------------------------------------------------
// conv_window_gen_if
// Pixel-in / window-out handshake bundle of the conv window generator.
//   pix_data/pix_valid/pix_ready : raster-order pixel stream into the generator
//   win_data/win_valid/win_ready : 3x3 window stream out to the filter array
// Modports:
//   master : the window generator (consumes pixels, produces windows)
//   slave  : its environment (produces pixels, consumes windows)
// -----------------------------------------------------------------------------
interface conv_window_gen_if #(
    parameter int DATA_W = cnn_pkg::DATA_W
);
    import cnn_pkg::*;

    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic [DATA_W-1:0] win_data [0:WIN_N-1];
    logic              win_valid;
    logic              win_ready;

    modport master (
        input  pix_data,
        input  pix_valid,
        output pix_ready,
        output win_data,
        output win_valid,
        input  win_ready
    );

    modport slave (
        output pix_data,
        output pix_valid,
        input  pix_ready,
        input  win_data,
        input  win_valid,
        output win_ready
    );

endinterface : conv_window_gen_if

// File: rtl/conv_window_gen_line_buffer.sv
// -----------------------------------------------------------------------------
// line_buffer
// One image row of storage, addressed by column. Read and write share one
// address; the read returns the word stored before this cycle's write, so a
// chained pair of buffers can shift a whole column down by one row per beat.
// Ports:
//   clk       : rising-edge clock
//   wr_en_i   : write wr_data_i at addr_i on the next edge
//   addr_i    : column address
//   wr_data_i : word to store
//   rd_data_o : current contents at addr_i (pre-write value)
// Contents are not reset; every location is rewritten before it is used.
// -----------------------------------------------------------------------------
module line_buffer #(
    parameter int DEPTH  = 28,
    parameter int DATA_W = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [0:DEPTH-1];

    // Read side: old contents are visible for the whole cycle of a write.
    assign rd_data_o = mem_q[addr_i];

    // Write side: store the new word at the shared address.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[addr_i] <= wr_data_i;
        end
    end

endmodule : line_buffer

// File: rtl/conv_window_gen.sv
// -----------------------------------------------------------------------------
// conv_window_gen
// Turns a raster-order pixel stream for one feature-map plane into 3x3
// windows (stride 1, no padding) for the filter/MAC array.
// Ports:
//   clk        : rising-edge clock
//   rst_n      : synchronous reset, ACTIVE HIGH despite the name
//   start      : one-cycle pulse, starts a frame when idle
//   win_if     : pixel input and window output handshakes (master modport)
//   busy       : frame in progress (streaming or flushing)
//   frame_done : one-cycle pulse after the last window of a frame is taken
// Two line buffers hold rows r-1 and r-2; a two-column shift register plus
// the column being read this beat forms the window. Windows whose bottom-right
// pixel has row>=2 and col>=2 are emitted one cycle after that pixel is taken.
// -----------------------------------------------------------------------------
module conv_window_gen #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int DATA_W = cnn_pkg::DATA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    conv_window_gen_if.master  win_if,
    output logic               busy,
    output logic               frame_done
);
    import cnn_pkg::*;

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    localparam logic [COL_W-1:0] COL_ZERO  = COL_W'(0);
    localparam logic [COL_W-1:0] COL_ONE   = COL_W'(1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(KERNEL_SIZE - 1);
    localparam logic [ROW_W-1:0] ROW_ZERO  = ROW_W'(0);
    localparam logic [ROW_W-1:0] ROW_ONE   = ROW_W'(1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(KERNEL_SIZE - 1);
    localparam logic [DATA_W-1:0] WORD_ZERO = DATA_W'(0);

    state_e            state_q;
    logic [COL_W-1:0]  col_q;
    logic [ROW_W-1:0]  row_q;
    logic              win_valid_q;
    logic              frame_done_q;

    // Shift register columns: index 0 is the older column, 1 the newer one.
    logic [DATA_W-1:0] top_q [0:1];
    logic [DATA_W-1:0] mid_q [0:1];
    logic [DATA_W-1:0] bot_q [0:1];
    logic [DATA_W-1:0] win_data_q [0:WIN_N-1];

    logic              pix_ready_s;
    logic              accept_s;
    logic              emit_s;
    logic              win_hs_s;
    logic [DATA_W-1:0] lb0_rd_s;
    logic [DATA_W-1:0] lb1_rd_s;

    // Handshake decode: a single output register means a pixel can be taken
    // whenever that register is empty or being emptied this cycle.
    always_comb begin
        pix_ready_s = 1'b0;
        if (state_q == S_STREAM) begin
            pix_ready_s = !win_valid_q || win_if.win_ready;
        end else begin
            pix_ready_s = 1'b0;
        end
        accept_s = pix_ready_s && win_if.pix_valid;
        emit_s   = accept_s && (row_q >= ROW_FIRST) && (col_q >= COL_FIRST);
        win_hs_s = win_valid_q && win_if.win_ready;
    end

    // Row r-1 store: refilled with the incoming pixel.
    line_buffer #(
        .DEPTH  (IMG_W),
        .DATA_W (DATA_W),
        .ADDR_W (COL_W)
    ) u_lb0 (
        .clk       (clk),
        .wr_en_i   (accept_s),
        .addr_i    (col_q),
        .wr_data_i (win_if.pix_data),
        .rd_data_o (lb0_rd_s)
    );

    // Row r-2 store: takes the word row r-1 is giving up.
    line_buffer #(
        .DEPTH  (IMG_W),
        .DATA_W (DATA_W),
        .ADDR_W (COL_W)
    ) u_lb1 (
        .clk       (clk),
        .wr_en_i   (accept_s),
        .addr_i    (col_q),
        .wr_data_i (lb0_rd_s),
        .rd_data_o (lb1_rd_s)
    );

    // Control FSM: frame sequencing, raster counters and output flags.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q      <= S_IDLE;
            col_q        <= COL_ZERO;
            row_q        <= ROW_ZERO;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;

            // A new window wins over release so back-to-back windows keep
            // win_valid high without a bubble.
            if (emit_s) begin
                win_valid_q <= 1'b1;
            end else if (win_hs_s) begin
                win_valid_q <= 1'b0;
            end else begin
                win_valid_q <= win_valid_q;
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_STREAM;
                        col_q   <= COL_ZERO;
                        row_q   <= ROW_ZERO;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_STREAM: begin
                    if (accept_s) begin
                        if (col_q == COL_LAST) begin
                            col_q <= COL_ZERO;
                            if (row_q == ROW_LAST) begin
                                state_q <= S_FLUSH;
                            end else begin
                                row_q <= row_q + ROW_ONE;
                            end
                        end else begin
                            col_q <= col_q + COL_ONE;
                        end
                    end else begin
                        state_q <= S_STREAM;
                    end
                end
                S_FLUSH: begin
                    // The final window is always pending here; wait for it.
                    if (win_hs_s) begin
                        frame_done_q <= 1'b1;
                        state_q      <= S_IDLE;
                    end else begin
                        state_q <= S_FLUSH;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Window datapath: the shift register advances on every accepted pixel,
    // including row starts, so columns 0 and 1 of a row just prime it.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                top_q[i] <= WORD_ZERO;
                mid_q[i] <= WORD_ZERO;
                bot_q[i] <= WORD_ZERO;
            end
            for (int k = 0; k < WIN_N; k++) begin
                win_data_q[k] <= WORD_ZERO;
            end
        end else begin
            if (accept_s) begin
                top_q[0] <= top_q[1];
                mid_q[0] <= mid_q[1];
                bot_q[0] <= bot_q[1];
                top_q[1] <= lb1_rd_s;
                mid_q[1] <= lb0_rd_s;
                bot_q[1] <= win_if.pix_data;
            end
            if (emit_s) begin
                win_data_q[0] <= top_q[0];
                win_data_q[1] <= top_q[1];
                win_data_q[2] <= lb1_rd_s;
                win_data_q[3] <= mid_q[0];
                win_data_q[4] <= mid_q[1];
                win_data_q[5] <= lb0_rd_s;
                win_data_q[6] <= bot_q[0];
                win_data_q[7] <= bot_q[1];
                win_data_q[8] <= win_if.pix_data;
            end
        end
    end

    assign win_if.pix_ready = pix_ready_s;
    assign win_if.win_valid = win_valid_q;
    assign win_if.win_data  = win_data_q;
    assign busy             = (state_q != S_IDLE);
    assign frame_done       = frame_done_q;

endmodule : conv_window_gen

// File: tb/tb_conv_window_gen.sv
// -----------------------------------------------------------------------------
// tb_conv_window_gen
// Directed bench for conv_window_gen: a 4x4 instance for the hand-computed
// frames and a 28x28 instance for a full-size frame with irregular handshakes.
// Pixel value is the raster index (for 4x4 that is 4r+c).
// -----------------------------------------------------------------------------
module tb_conv_window_gen;
    import cnn_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Index 0 drives the 4x4 instance, index 1 the 28x28 instance.
    logic        rst  [2];
    logic        st   [2];
    logic        pv   [2];
    logic [31:0] pd   [2];
    logic        wr   [2];
    logic        prdy [2];
    logic        wv   [2];
    logic        bz   [2];
    logic        fd   [2];
    logic [31:0] wd   [2][WIN_N];

    conv_window_gen_if #(.DATA_W(32)) if_s ();
    conv_window_gen_if #(.DATA_W(32)) if_l ();

    conv_window_gen #(.IMG_W(4), .IMG_H(4), .DATA_W(32)) dut_s (
        .clk        (clk),
        .rst_n      (rst[0]),
        .start      (st[0]),
        .win_if     (if_s),
        .busy       (bz[0]),
        .frame_done (fd[0])
    );

    conv_window_gen #(.IMG_W(28), .IMG_H(28), .DATA_W(32)) dut_l (
        .clk        (clk),
        .rst_n      (rst[1]),
        .start      (st[1]),
        .win_if     (if_l),
        .busy       (bz[1]),
        .frame_done (fd[1])
    );

    assign if_s.pix_valid = pv[0];
    assign if_s.pix_data  = pd[0];
    assign if_s.win_ready = wr[0];
    assign if_l.pix_valid = pv[1];
    assign if_l.pix_data  = pd[1];
    assign if_l.win_ready = wr[1];
    assign prdy[0] = if_s.pix_ready;
    assign prdy[1] = if_l.pix_ready;
    assign wv[0]   = if_s.win_valid;
    assign wv[1]   = if_l.win_valid;

    for (genvar k = 0; k < WIN_N; k++) begin : g_wd
        assign wd[0][k] = if_s.win_data[k];
        assign wd[1][k] = if_l.win_data[k];
    end

    // First window of a 4x4 frame, hand-computed.
    win_t exp_first;
    initial begin
        exp_first[0] = 32'd0;  exp_first[1] = 32'd1; exp_first[2] = 32'd2;
        exp_first[3] = 32'd4;  exp_first[4] = 32'd5; exp_first[5] = 32'd6;
        exp_first[6] = 32'd8;  exp_first[7] = 32'd9; exp_first[8] = 32'd10;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Element k of the n-th window of a w-wide frame whose pixels are indices.
    function automatic logic [31:0] exp_pix(input int w, input int n, input int k);
        int r;
        int c;
        r = 2 + n / (w - 2);
        c = 2 + n % (w - 2);
        return 32'((r - 2 + k / 3) * w + (c - 2 + k % 3));
    endfunction

    task automatic pulse_start(input int s);
        @(posedge clk); #1;
        st[s] = 1'b1;
        @(posedge clk); #1;
        st[s] = 1'b0;
    endtask

    // One full frame. rnd: random pix_valid/win_ready; stall: cycles win_ready
    // is held low while the first window is pending; midstart: pulse start
    // while busy.
    task automatic run_frame(input int s, input int w, input int h, input bit rnd,
                             input int stall, input bit midstart);
        int pidx;
        int nwin;
        int cyc;
        int nexp;
        int stall_cnt;
        pidx = 0; nwin = 0; cyc = 0; stall_cnt = 0;
        nexp = (w - 2) * (h - 2);
        pulse_start(s);
        while (nwin < nexp && cyc < 20000) begin
            pv[s] = (pidx < w * h) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
            pd[s] = 32'(pidx);
            wr[s] = !(nwin == 0 && stall_cnt < stall) &&
                    (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
            st[s] = midstart && (cyc == 3);
            @(negedge clk);
            if (cyc == 0) check_eq($sformatf("s%0d_busy_stream", s), 32'(bz[s]), 32'd1);
            if (wv[s] && !wr[s] && stall_cnt < stall) begin
                check_eq($sformatf("s%0d_stall_pix_ready", s), 32'(prdy[s]), 32'd0);
                for (int k = 0; k < WIN_N; k++)
                    check_eq($sformatf("s%0d_stall_hold_e%0d", s, k), wd[s][k], exp_first[k]);
                stall_cnt++;
            end
            if (wv[s] && wr[s]) begin
                for (int k = 0; k < WIN_N; k++)
                    check_eq($sformatf("s%0d_win%0d_e%0d", s, nwin, k), wd[s][k], exp_pix(w, nwin, k));
                nwin++;
            end
            if (pv[s] && prdy[s]) pidx++;
            @(posedge clk); #1;
            cyc++;
        end
        st[s] = 1'b0;
        pv[s] = 1'b0;
        wr[s] = 1'b0;
        check_eq($sformatf("s%0d_window_count", s), 32'(nwin), 32'(nexp));
        check_eq($sformatf("s%0d_stall_cycles", s), 32'(stall_cnt), 32'(stall));
        @(negedge clk);
        check_eq($sformatf("s%0d_pixels_taken", s), 32'(pidx), 32'(w * h));
        check_eq($sformatf("s%0d_frame_done", s), 32'(fd[s]), 32'd1);
        check_eq($sformatf("s%0d_done_no_valid", s), 32'(wv[s]), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq($sformatf("s%0d_done_pulse_end", s), 32'(fd[s]), 32'd0);
        check_eq($sformatf("s%0d_idle_busy", s), 32'(bz[s]), 32'd0);
    endtask

    // Ten pixels of a 4x4 frame, then reset while pixel 10 (a window) is offered.
    task automatic reset_mid_frame();
        int pidx;
        int cyc;
        pidx = 0; cyc = 0;
        pulse_start(0);
        wr[0] = 1'b1;
        while (pidx < 10 && cyc < 100) begin
            pv[0] = 1'b1;
            pd[0] = 32'(pidx);
            @(negedge clk);
            if (pv[0] && prdy[0]) pidx++;
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("rst_pixels_before", 32'(pidx), 32'd10);
        pd[0]  = 32'd10;
        pv[0]  = 1'b1;
        rst[0] = 1'b1;
        @(negedge clk);
        check_eq("rst_busy_before", 32'(bz[0]), 32'd1);
        @(posedge clk); #1;
        rst[0] = 1'b0;
        pv[0]  = 1'b0;
        wr[0]  = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_win_valid", 32'(wv[0]), 32'd0);
        check_eq("rst_mid_pix_ready", 32'(prdy[0]), 32'd0);
        check_eq("rst_mid_busy", 32'(bz[0]), 32'd0);
        check_eq("rst_mid_win_data8", wd[0][8], 32'd0);
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            rst[s] = 1'b1; st[s] = 1'b0; pv[s] = 1'b0; pd[s] = 32'd0; wr[s] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);
        check_eq("reset_pix_ready", 32'(prdy[0]), 32'd0);
        check_eq("reset_win_valid", 32'(wv[0]), 32'd0);
        check_eq("reset_busy", 32'(bz[0]), 32'd0);
        check_eq("reset_frame_done", 32'(fd[0]), 32'd0);
        check_eq("reset_win_data0", wd[0][0], 32'd0);
        check_eq("reset_win_data8", wd[0][8], 32'd0);

        // Pixels offered while idle are not taken and do not start a frame.
        @(posedge clk); #1;
        pv[0] = 1'b1;
        pd[0] = 32'h3f80_0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("idle_pix_ready", 32'(prdy[0]), 32'd0);
            check_eq("idle_busy", 32'(bz[0]), 32'd0);
            @(posedge clk); #1;
        end
        pv[0] = 1'b0;

        run_frame(0, 4, 4, 1'b0, 0, 1'b0);   // plain frame
        run_frame(0, 4, 4, 1'b0, 5, 1'b0);   // consumer stall on first window
        reset_mid_frame();
        run_frame(0, 4, 4, 1'b0, 0, 1'b0);   // clean frame after reset
        run_frame(0, 4, 4, 1'b0, 0, 1'b1);   // start while busy is ignored
        run_frame(0, 4, 4, 1'b1, 0, 1'b0);   // back-to-back, irregular handshakes
        run_frame(1, 28, 28, 1'b1, 0, 1'b0); // full-size frame

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_conv_window_gen
